cavlc_blk_sched: RTL and testbench



---
 rtl/cavlc_sched_pkg.sv | 35 +++
 rtl/cavlc_blk_sched_if.sv | 62 ++++++
 rtl/cavlc_blk_sched.sv | 159 +++++++++++++++
 tb/tb_cavlc_blk_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cavlc_sched_pkg
//  Description : Shared types and helpers for the CAVLC per-macroblock
//                block scheduler (state encoding, block count, block offset).
//  Revision    : 1.0  initial release
// ============================================================================
package cavlc_sched_pkg;

  localparam int BLK_PER_MB = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_e;

  // 4x4-block column/row inside the 16x16 macroblock, in units of 4 pixels
  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
  } blk_xy_t;

  // luma4x4BlkIdx interleaves 8x8 quadrant and 4x4 sub-block bits:
  // column bits are idx[2] (8x8 half) and idx[0] (4x4 half), rows idx[3]/idx[1]
  function automatic blk_xy_t blk_xy(input logic [3:0] idx);
    blk_xy_t r;
    r.x = {idx[2], idx[0]};
    r.y = {idx[3], idx[1]};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_blk_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : cavlc_blk_sched_if
//  Description : Bundle of macroblock control, statistics handshake, encoder
//                launch/result and packer valid/ready signals around the
//                CAVLC block scheduler. master = scheduler side.
//  Revision    : 1.0  initial release
// ============================================================================
interface cavlc_blk_sched_if #(
  parameter int CODE_W = 128,
  parameter int LEN_W  = 7
);
  // macroblock control
  logic              mb_start;
  logic [9:0]        mb_topleft_x;
  logic [9:0]        mb_topleft_y;
  logic              mb_busy;
  logic              mb_done;
  logic              protocol_err;
  // upstream statistics
  logic              stat_valid;
  logic              stat_ready;
  logic [3:0]        blk_idx;
  // encoder
  logic              enc_start;
  logic [9:0]        enc_topleft_x;
  logic [9:0]        enc_topleft_y;
  logic              enc_ready;
  logic              enc_valid;
  logic [CODE_W-1:0] enc_code;
  logic [LEN_W-1:0]  enc_bits;
  // bit packer
  logic              pk_valid;
  logic              pk_ready;
  logic [CODE_W-1:0] pk_code;
  logic [LEN_W-1:0]  pk_bits;
  logic              pk_last;

  modport master (
    input  mb_start, mb_topleft_x, mb_topleft_y,
    output mb_busy, mb_done, protocol_err,
    input  stat_valid,
    output stat_ready, blk_idx,
    output enc_start, enc_topleft_x, enc_topleft_y,
    input  enc_ready, enc_valid, enc_code, enc_bits,
    output pk_valid, pk_code, pk_bits, pk_last,
    input  pk_ready
  );

  modport slave (
    output mb_start, mb_topleft_x, mb_topleft_y,
    input  mb_busy, mb_done, protocol_err,
    output stat_valid,
    input  stat_ready, blk_idx,
    input  enc_start, enc_topleft_x, enc_topleft_y,
    output enc_ready, enc_valid, enc_code, enc_bits,
    input  pk_valid, pk_code, pk_bits, pk_last,
    output pk_ready
  );

endinterface
`default_nettype wire

// File: rtl/cavlc_blk_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cavlc_blk_sched
//  Description : Walks the 16 luma 4x4 blocks of a macroblock, launches the
//                CAVLC encoder once per block when statistics are available,
//                and forwards each result to the bit packer through a
//                one-entry valid/ready buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module cavlc_blk_sched
  import cavlc_sched_pkg::*;
#(
  parameter int CODE_W = 128,
  parameter int LEN_W  = 7
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cavlc_blk_sched_if.master bus
);

  sched_state_e      state_q, state_d;
  logic [3:0]        blk_idx_q, blk_idx_d;
  logic [5:0]        mbx_q, mbx_d;
  logic [5:0]        mby_q, mby_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              err_arm_q, err_arm_d;
  logic              pk_valid_q, pk_valid_d;
  logic [CODE_W-1:0] pk_code_q, pk_code_d;
  logic [LEN_W-1:0]  pk_bits_q, pk_bits_d;
  logic              pk_last_q, pk_last_d;

  logic              stat_rdy;
  logic              launch;
  logic              pk_hs;
  logic              last_blk;
  blk_xy_t           xy;

  // Launch permission uses the registered buffer flag, so a packer handshake
  // and a launch never happen in the same cycle
  always_comb begin
    stat_rdy = (state_q == ST_FETCH) && bus.enc_ready && !pk_valid_q;
    launch   = stat_rdy && bus.stat_valid;
    pk_hs    = pk_valid_q && bus.pk_ready;
    last_blk = (blk_idx_q == 4'(BLK_PER_MB - 1));
    xy       = blk_xy(blk_idx_q);
  end

  // Next-state: block walk, result buffer and sticky protocol error
  always_comb begin
    state_d    = state_q;
    blk_idx_d  = blk_idx_q;
    mbx_d      = mbx_q;
    mby_d      = mby_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_arm_d  = err_arm_q;
    pk_valid_d = pk_valid_q;
    pk_code_d  = pk_code_q;
    pk_bits_d  = pk_bits_q;
    pk_last_d  = pk_last_q;

    if (pk_hs) begin
      pk_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.mb_start) begin
          mbx_d     = bus.mb_topleft_x[9:4];
          mby_d     = bus.mb_topleft_y[9:4];
          blk_idx_d = 4'd0;
          err_arm_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (launch) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.enc_valid) begin
          pk_valid_d = 1'b1;
          pk_code_d  = bus.enc_code;
          pk_bits_d  = bus.enc_bits;
          pk_last_d  = last_blk;
          if (last_blk) begin
            state_d = ST_FLUSH;
          end else begin
            blk_idx_d = blk_idx_q + 4'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FLUSH: begin
        if (pk_hs) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A second start while a macroblock is in flight is dropped
    if (bus.mb_start && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end
    // Results arriving outside RUN are dropped; masked until the first start
    // so a result from before a reset cannot raise the flag
    if (bus.enc_valid && (state_q != ST_RUN) && err_arm_q) begin
      err_d = 1'b1;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      blk_idx_q  <= 4'd0;
      mbx_q      <= 6'd0;
      mby_q      <= 6'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_arm_q  <= 1'b0;
      pk_valid_q <= 1'b0;
      pk_code_q  <= '0;
      pk_bits_q  <= '0;
      pk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_idx_q  <= blk_idx_d;
      mbx_q      <= mbx_d;
      mby_q      <= mby_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_arm_q  <= err_arm_d;
      pk_valid_q <= pk_valid_d;
      pk_code_q  <= pk_code_d;
      pk_bits_q  <= pk_bits_d;
      pk_last_q  <= pk_last_d;
    end
  end

  assign bus.mb_busy       = (state_q != ST_IDLE);
  assign bus.mb_done       = done_q;
  assign bus.protocol_err  = err_q;
  assign bus.stat_ready    = stat_rdy;
  assign bus.blk_idx       = blk_idx_q;
  assign bus.enc_start     = launch;
  assign bus.enc_topleft_x = {mbx_q, xy.x, 2'b00};
  assign bus.enc_topleft_y = {mby_q, xy.y, 2'b00};
  assign bus.pk_valid      = pk_valid_q;
  assign bus.pk_code       = pk_code_q;
  assign bus.pk_bits       = pk_bits_q;
  assign bus.pk_last       = pk_last_q;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_blk_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cavlc_blk_sched
//  Description : Self-checking bench for cavlc_blk_sched with an 18-cycle
//                encoder model, launch/packer logs and a pixel-position
//                reference derived from H.264 inverse raster scan.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cavlc_blk_sched;

  localparam int CODE_W = 128;
  localparam int LEN_W  = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cavlc_blk_sched_if #(.CODE_W(CODE_W), .LEN_W(LEN_W)) bus ();

  cavlc_blk_sched #(.CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  int cyc   = 0;

  typedef struct {
    int idx;
    int x;
    int y;
    int cyc;
  } launch_t;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  bits;
    logic              last;
    int                cyc;
  } pk_t;

  launch_t lq[$];
  pk_t     hq[$];
  pk_t     eq[$];
  int      done_cnt = 0;
  int      done_cyc = 0;
  int      busy_cyc = 0;
  logic    busy_prev = 1'b0;

  // encoder model: result pulse 18 cycles after launch
  int                enc_cnt = 0;
  logic              ev = 1'b0;
  logic              spur = 1'b0;
  logic [CODE_W-1:0] ev_code = '0;
  logic [LEN_W-1:0]  ev_bits = '0;

  assign bus.enc_valid = ev | spur;
  assign bus.enc_code  = ev_code;
  assign bus.enc_bits  = ev_bits;
  assign bus.enc_ready = (enc_cnt == 0) && !ev;

  always @(posedge clk) begin
    logic [CODE_W-1:0] c;
    logic [LEN_W-1:0]  b;
    ev <= 1'b0;
    if (enc_cnt != 0) begin
      enc_cnt <= enc_cnt - 1;
      if (enc_cnt == 1) begin
        c = {$urandom, $urandom, $urandom, $urandom};
        b = LEN_W'($urandom_range(1, 127));
        ev      <= 1'b1;
        ev_code <= c;
        ev_bits <= b;
        eq.push_back('{c, b, 1'b0, cyc});
      end
    end
    if (bus.enc_start) enc_cnt <= 17;
  end

  // mid-cycle observer of launches, packer handshakes and done pulses
  always @(negedge clk) begin
    cyc++;
    if (bus.enc_start)
      lq.push_back('{int'(bus.blk_idx), int'(bus.enc_topleft_x), int'(bus.enc_topleft_y), cyc});
    if (bus.pk_valid && bus.pk_ready)
      hq.push_back('{bus.pk_code, bus.pk_bits, bus.pk_last, cyc});
    if (bus.mb_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.mb_busy && !busy_prev) busy_cyc = cyc;
    busy_prev = bus.mb_busy;
  end

  // reference pixel position: InverseRasterScan of 8x8 quadrant then 4x4 block
  function automatic int ref_x(input int mbx, input int idx);
    return (mbx / 16) * 16 + ((idx / 4) % 2) * 8 + ((idx % 4) % 2) * 4;
  endfunction
  function automatic int ref_y(input int mby, input int idx);
    return (mby / 16) * 16 + ((idx / 4) / 2) * 8 + ((idx % 4) / 2) * 4;
  endfunction

  task automatic chk(input string tag, input logic [CODE_W-1:0] got, input logic [CODE_W-1:0] exp);
    ntot++;
    assert (got === exp) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rnd(input bit rnd);
    if (rnd) begin
      bus.stat_valid = ($urandom_range(0, 3) != 0);
      bus.pk_ready   = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_launches(input int n, input int budget, input bit rnd);
    int k = 0;
    while (lq.size() < n && k < budget) begin
      drive_rnd(rnd);
      step(1);
      k++;
    end
    if (lq.size() < n) chk("timeout_launch", lq.size(), n);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      drive_rnd(rnd);
      step(1);
      k++;
    end
    if (done_cnt == 0) chk("timeout_done", done_cnt, 1);
  endtask

  task automatic start_mb(input int x, input int y);
    lq.delete();
    hq.delete();
    eq.delete();
    done_cnt = 0;
    bus.mb_topleft_x = 10'(x);
    bus.mb_topleft_y = 10'(y);
    bus.mb_start = 1'b1;
    step(1);
    bus.mb_start = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", bus.mb_busy, 0);
    chk("rst_done", bus.mb_done, 0);
    chk("rst_err", bus.protocol_err, 0);
    chk("rst_blk_idx", bus.blk_idx, 0);
    chk("rst_pk_valid", bus.pk_valid, 0);
    chk("rst_pk_code", bus.pk_code, 0);
    chk("rst_pk_bits", bus.pk_bits, 0);
    chk("rst_pk_last", bus.pk_last, 0);
    chk("rst_enc_start", bus.enc_start, 0);
    chk("rst_stat_ready", bus.stat_ready, 0);
    chk("rst_tl_x", bus.enc_topleft_x, 0);
    chk("rst_tl_y", bus.enc_topleft_y, 0);
  endtask

  task automatic check_mb(input int mbx, input int mby);
    chk("launch_count", lq.size(), 16);
    chk("pk_count", hq.size(), 16);
    chk("done_count", done_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      if (i < lq.size()) begin
        chk("launch_idx", lq[i].idx, i);
        chk("launch_x", lq[i].x, ref_x(mbx, i));
        chk("launch_y", lq[i].y, ref_y(mby, i));
      end
      if (i < hq.size() && i < eq.size()) begin
        chk("pk_code", hq[i].code, eq[i].code);
        chk("pk_bits", hq[i].bits, eq[i].bits);
        chk("pk_last", hq[i].last, (i == 15));
      end
    end
  endtask

  initial begin
    int mx, my, exp_cyc, dly;
    logic any;
    logic [CODE_W-1:0] saved_code;
    logic [LEN_W-1:0]  saved_bits;

    rst = 1'b1;
    bus.mb_start = 1'b0;
    bus.mb_topleft_x = '0;
    bus.mb_topleft_y = '0;
    bus.stat_valid = 1'b0;
    bus.pk_ready = 1'b0;
    step(3);
    check_reset_vals();
    rst = 1'b0;
    step(2);

    // MB 1: free-flowing, fixed position
    bus.stat_valid = 1'b1;
    bus.pk_ready = 1'b1;
    start_mb(32, 16);
    wait_done(500, 1'b0);
    check_mb(32, 16);
    if (lq.size() == 16) begin
      chk("idx5_x", lq[5].x, 44);
      chk("idx5_y", lq[5].y, 16);
      chk("idx10_x", lq[10].x, 32);
      chk("idx10_y", lq[10].y, 28);
      chk("idx15_x", lq[15].x, 44);
      chk("idx15_y", lq[15].y, 28);
      chk("first_launch_cycle", lq[0].cyc, busy_cyc);
      chk("launch_spacing", lq[15].cyc - lq[0].cyc, 300);
    end
    dly = done_cyc - busy_cyc;
    chk("mb_latency_window", (dly >= 318 && dly <= 322), 1);
    step(1);
    chk("mb1_busy_clear", bus.mb_busy, 0);
    chk("mb1_err", bus.protocol_err, 0);

    // MB 2: stat_valid gap, mb_start in RUN, packer stall after block 3
    mx = $urandom_range(0, 1023);
    my = $urandom_range(0, 1023);
    bus.stat_valid = 1'b0;
    start_mb(mx, my);
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any |= bus.enc_start;
      step(1);
    end
    chk("no_launch_stat_low", any, 0);
    chk("no_launch_logged", lq.size(), 0);
    bus.stat_valid = 1'b1;
    exp_cyc = cyc + 1;
    #1;
    chk("launch_on_stat", bus.enc_start, 1);
    step(3);
    chk("err_before_restart", bus.protocol_err, 0);
    bus.mb_topleft_x = 10'($urandom);
    bus.mb_topleft_y = 10'($urandom);
    bus.mb_start = 1'b1;
    step(1);
    bus.mb_start = 1'b0;
    chk("err_restart_in_run", bus.protocol_err, 1);
    chk("busy_after_restart", bus.mb_busy, 1);
    if (lq.size() > 0) chk("launch_cycle_stat", lq[0].cyc, exp_cyc);
    wait_launches(4, 200, 1'b0);
    bus.pk_ready = 1'b0;
    begin
      int k = 0;
      while (!bus.pk_valid && k < 40) begin
        step(1);
        k++;
      end
    end
    chk("blk3_captured", bus.pk_valid, 1);
    saved_code = bus.pk_code;
    saved_bits = bus.pk_bits;
    any = 1'b0;
    for (int i = 0; i < 50; i++) begin
      any |= bus.stat_ready | bus.enc_start;
      step(1);
    end
    chk("stall_no_ready", any, 0);
    chk("stall_launches", lq.size(), 4);
    chk("stall_code_held", bus.pk_code, saved_code);
    chk("stall_bits_held", bus.pk_bits, saved_bits);
    if (eq.size() > 3) chk("stall_code_model", saved_code, eq[3].code);
    bus.pk_ready = 1'b1;
    wait_done(2000, 1'b1);
    check_mb(mx, my);

    // MB 3: spurious result in FETCH, then reset during block 7
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("err_cleared_by_rst", bus.protocol_err, 0);
    bus.stat_valid = 1'b0;
    start_mb($urandom_range(0, 1023), $urandom_range(0, 1023));
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    chk("err_spurious", bus.protocol_err, 1);
    chk("spurious_no_capture", bus.pk_valid, 0);
    wait_launches(8, 2000, 1'b1);
    step(5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals();
    step(2);
    rst = 1'b0;
    step(25);
    chk("ghost_err_masked", bus.protocol_err, 0);
    chk("ghost_no_capture", bus.pk_valid, 0);

    // MB 4: fresh macroblock at the far corner, random flow control
    start_mb(1023, 1008);
    wait_done(2000, 1'b1);
    check_mb(1023, 1008);
    if (lq.size() == 16) begin
      chk("corner_x", lq[15].x, 1020);
      chk("corner_y", lq[15].y, 1020);
    end
    step(1);
    chk("mb4_err", bus.protocol_err, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
